// File: rtl/led_refresh_ctrl_pkg.sv
// led_refresh_ctrl_pkg: converter FSM encoding, score clamp and default divider values
package led_refresh_ctrl_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_WAIT} conv_state_t;
  localparam logic [13:0] SCORE_MAX = 14'd9999;
  localparam int DEF_SCAN_DIV = 100000;
  localparam int DEF_FLASH_DIV = 25000000;
  localparam int DEF_REFRESH_DIV = 5000000;
  localparam int DEF_P2S_GAP = 200;
  localparam int DEF_BCD_LAT = 32;
  function automatic logic [13:0] clamp_score(input logic [13:0] v);
    return v > SCORE_MAX ? SCORE_MAX : v;
  endfunction
endpackage

// File: rtl/tick_gen.sv
// tick_gen: divide-by-DIV prescaler with synchronous clear and a one-cycle tick
module tick_gen #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);
  localparam int W = DIV > 1 ? $clog2(DIV) : 1;
  logic [W-1:0] cnt;
  assign tick = !clr && cnt == W'(DIV - 1);
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else if (clr || tick) cnt <= '0;
    else cnt <= cnt + 1'b1;
endmodule

// File: rtl/led_refresh_ctrl.sv
// led_refresh_ctrl: digit scan, blink phase, rate-limited panel refresh and score-to-BCD handshake
module led_refresh_ctrl
  import led_refresh_ctrl_pkg::*;
#(
  parameter int SCAN_DIV = DEF_SCAN_DIV,
  parameter int FLASH_DIV = DEF_FLASH_DIV,
  parameter int REFRESH_DIV = DEF_REFRESH_DIV,
  parameter int P2S_GAP = DEF_P2S_GAP,
  parameter int BCD_LAT = DEF_BCD_LAT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [13:0] score_in,
  input  logic        score_we,
  input  logic        flash_en,
  output logic [13:0] score,
  output logic        new_score,
  output logic        flash,
  output logic        p2s_start,
  output logic [1:0]  scan,
  output logic        busy
);
  localparam int GW = $clog2(P2S_GAP + 1);
  localparam int LW = BCD_LAT > 1 ? $clog2(BCD_LAT) : 1;
  logic scan_tick, flash_tick, ref_tick;
  logic flash_nxt, started, p2s_pend, p2s_pend_n, p2s_fire;
  logic [GW-1:0] gap;
  conv_state_t state, state_n;
  logic [LW-1:0] wcnt;
  logic [13:0] pend_val, wr_val;
  logic pend_flag, accept, consume;
  tick_gen #(.DIV(SCAN_DIV)) u_scan (.clk(clk), .rst(rst), .clr(1'b0), .tick(scan_tick));
  tick_gen #(.DIV(FLASH_DIV)) u_flash (.clk(clk), .rst(rst), .clr(!flash_en), .tick(flash_tick));
  tick_gen #(.DIV(REFRESH_DIV)) u_refresh (.clk(clk), .rst(rst), .clr(1'b0), .tick(ref_tick));
  // a refresh request fires in the same edge the flash change becomes visible
  assign flash_nxt = flash_en && (flash ^ flash_tick);
  assign p2s_pend_n = p2s_pend || !started || ref_tick || (flash_nxt != flash);
  assign p2s_fire = p2s_pend_n && gap == '0;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      scan <= '0;
      flash <= 1'b0;
      started <= 1'b0;
      p2s_pend <= 1'b0;
      p2s_start <= 1'b0;
      gap <= '0;
    end else begin
      scan <= scan + {1'b0, scan_tick};
      flash <= flash_nxt;
      started <= 1'b1;
      p2s_pend <= p2s_pend_n && !p2s_fire;
      p2s_start <= p2s_fire;
      gap <= p2s_fire ? GW'(P2S_GAP - 1) : gap != '0 ? gap - 1'b1 : gap;
    end
  // writes equal to the displayed score are dropped unless they replace a pending value
  assign wr_val = clamp_score(score_in);
  assign accept = score_we && (pend_flag || wr_val != score);
  assign consume = state == ST_IDLE && pend_flag;
  always_comb begin
    busy = state != ST_IDLE;
    state_n = state == ST_IDLE ? (pend_flag ? ST_LOAD : ST_IDLE)
            : state == ST_LOAD ? ST_WAIT
            : wcnt == LW'(BCD_LAT - 1) ? ST_IDLE : ST_WAIT;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= ST_IDLE;
      wcnt <= '0;
      score <= '0;
      new_score <= 1'b0;
      pend_val <= '0;
      pend_flag <= 1'b0;
    end else begin
      state <= state_n;
      wcnt <= state == ST_WAIT ? wcnt + 1'b1 : '0;
      new_score <= consume;
      if (consume) score <= pend_val;
      if (accept) pend_val <= wr_val;
      pend_flag <= accept || (pend_flag && !consume);
    end
endmodule

// File: doc/led_refresh_ctrl.md
LED_REFRESH_CTRL -- requirements
Module: led_refresh_ctrl

Interface
REQ-001 Parameter SCAN_DIV, 100000, clk cycles per digit-scan step.
REQ-002 Parameter FLASH_DIV, 25000000, clk cycles per flash half-period.
REQ-003 Parameter REFRESH_DIV, 5000000, clk cycles between periodic serial-panel refreshes.
REQ-004 Parameter P2S_GAP, 200, minimum clk cycles between p2s_start pulses.
REQ-005 Parameter BCD_LAT, 32, clk cycles the binary-to-BCD converter needs after start.
REQ-006 clk  in  1  single system clock; all state on rising edge.
REQ-007 rst  in  1  asynchronous, active-low reset.
REQ-008 score_in  in  14  new binary score.
REQ-009 score_we  in  1  score_in valid this cycle.
REQ-010 flash_en  in  1  enable blinking of serial-panel upper half.
REQ-011 score  out  14  registered score presented to the BCD converter.
REQ-012 new_score  out  1  one-cycle converter start pulse.
REQ-013 flash  out  1  current blink phase.
REQ-014 p2s_start  out  1  one-cycle serial-shift start pulse.
REQ-015 scan  out  2  digit select for 4-digit multiplex.
REQ-016 busy  out  1  high while the converter FSM is not IDLE.

Function
REQ-017 scan SHALL increment by 1 on every SCAN_DIV-th cycle, wrapping 3->0.
REQ-018 While flash_en=1, flash SHALL toggle every FLASH_DIV cycles; while flash_en=0, flash SHALL be 0 and the flash prescaler held at 0.
REQ-019 A p2s request SHALL be raised by: any change of flash; the REFRESH_DIV tick; the first cycle after reset release.
REQ-020 p2s_start SHALL pulse for exactly one cycle, the cycle after a request, unless fewer than P2S_GAP cycles have elapsed since the previous pulse, in which case the request SHALL stay pending and fire on the first permitted cycle.
REQ-021 Multiple requests while pending SHALL merge into a single pulse.
REQ-022 score_we SHALL capture min(score_in, 9999) into a pending register and set a pending flag; a later write before consumption SHALL overwrite it (latest wins).
REQ-023 Converter FSM: IDLE -> (pending) LOAD -> WAIT -> IDLE; LOAD drives score=pending value, pulses new_score, clears pending flag; WAIT lasts exactly BCD_LAT cycles.
REQ-024 score SHALL remain stable from LOAD through end of WAIT; writes arriving in LOAD/WAIT SHALL only update the pending register.
REQ-025 score_we in the same cycle the FSM consumes pending SHALL be retained as a new pending value, not lost.
REQ-026 Latency score_we (FSM IDLE) -> new_score SHALL be 2 cycles.
REQ-027 A write equal to the currently displayed score with no pending value SHALL NOT start a conversion.

Reset
REQ-028 On rst=0: score=0, new_score=0, flash=0, p2s_start=0, scan=0, busy=0, all prescalers and gap counter 0, pending cleared, FSM IDLE.
REQ-029 Reset asserted mid-WAIT or with p2s pending SHALL abort immediately; no pulse SHALL issue until the REQ-019 post-reset request.

Structure
REQ-030 Shared package holds FSM state encoding, 9999 clamp constant and default divider values.
REQ-031 One sub-module tick_gen (parameterised divider with clear input, 1-cycle tick output) SHALL be instantiated for scan, flash and refresh.

Verification (SCAN_DIV=4, FLASH_DIV=8, REFRESH_DIV=50, P2S_GAP=6, BCD_LAT=5)
REQ-032 Release reset, hold 40 cycles -> scan 0,1,2,3,0 every 4 cycles; one p2s_start at cycle 1 after release.
REQ-033 flash_en=1 at t=10 -> flash toggles every 8 cycles, one p2s_start per toggle; flash_en=0 -> flash=0 within 1 cycle plus one p2s_start.
REQ-034 REFRESH tick 2 cycles after a flash-triggered pulse -> merged/delayed pulse exactly 6 cycles after previous, never closer.
REQ-035 score_we 1234 while IDLE -> new_score 2 cycles later, score=1234, busy high 6 cycles (LOAD+5 WAIT).
REQ-036 Writes 10, 20, 30 during WAIT -> exactly one further conversion with score=30; write 12000 -> score=9999.
REQ-037 rst=0 during WAIT then release -> busy=0, score=0, no new_score until next score_we.
